uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rd  input  1  MEM-stage read strobe.
REQ-006 SHALL have port wr  input  1  MEM-stage write strobe.
REQ-007 SHALL have port addr  input  32  MEM-stage byte address.
REQ-008 SHALL have port wdata  input  32  MEM-stage store data.
REQ-009 SHALL have port rdata  output  32  read data; 0 when the read is not addressed to this block, so the MEM stage can OR it with other sources.
REQ-010 SHALL have port uart_rx  input  1  serial line in, idle high, asynchronous.
REQ-011 SHALL have port uart_tx  output  1  serial line out, idle high.
REQ-012 SHALL have port irq  output  1  level interrupt request to the control unit.

Function
REQ-013 SHALL decode TXD = 0x40000018, RXD = 0x4000001C and CON = 0x40000020; addr[1:0] SHALL be ignored.
REQ-014 rdata SHALL be combinational and valid in the same cycle as rd.
- RXD read: {24'b0, rx_byte}.
- CON read: {27'b0, tx_busy, tx_done, rx_done, rx_ie, tx_ie}.
REQ-015 A write to CON SHALL update tx_ie = wdata[0] and rx_ie = wdata[1] only; bits 2-4 SHALL be read-only.
REQ-016 A tick generator SHALL assert a 1-cycle tick every DIV = CLK_HZ/(BAUD*16) cycles, counter wrapping from DIV-1 to 0; DIV < 1 SHALL be treated as 1.
REQ-017 Frame format SHALL be 8N1, LSB first; each bit lasts 16 ticks.
REQ-018 TX FSM SHALL have states IDLE, START, DATA, STOP.
- A TXD write in IDLE latches wdata[7:0], sets tx_busy and enters START on the next tick boundary.
- START drives 0.
- DATA shifts out 8 bits.
- STOP drives 1, then returns to IDLE, clears tx_busy and sets tx_done.
REQ-019 A TXD write while tx_busy = 1 SHALL be ignored, with no effect on the frame in flight.
REQ-020 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, STOP.
- A falling edge in IDLE enters START.
- If the line is high at tick 8, the frame is a false start and the FSM returns to IDLE.
- Otherwise the FSM samples each data bit at tick 8 of its bit time.
- In STOP, at tick 8 the FSM returns to IDLE.
- stop bit = 1: load rx_byte and set rx_done.
- stop bit = 0 (framing error): discard the byte and leave rx_done unchanged.
REQ-022 rx_done and tx_done SHALL be sticky and SHALL clear in the cycle after a CON read (rd = 1, addr = CON).
- A set event in the same cycle as the clearing read wins; the flag stays 1.
REQ-023 A new received byte SHALL overwrite rx_byte even when rx_done is already 1 (no overrun flag).
REQ-024 TX and RX SHALL operate fully concurrently; a simultaneous TXD write and RXD read SHALL both take effect.

Reset
REQ-025 On reset the block SHALL return to the following state; reset mid-frame SHALL abort the frame immediately.
- uart_tx = 1, irq = 0.
- Both FSMs in IDLE.
- tx_busy, tx_done, rx_done, tx_ie, rx_ie = 0.
- rx_byte = 0, tick counter = 0.
- Synchronizer flops = 1.

Configuration
REQ-026 With UART_IRQ_EN defined, irq SHALL be registered and equal (tx_ie & tx_done) | (rx_ie & rx_done), one cycle behind the flags.
REQ-027 Without UART_IRQ_EN, irq SHALL be tied to 0 and tx_ie/rx_ie SHALL remain storable and readable.

Structure
REQ-028 Register addresses, CON bit positions and the FSM state encoding SHALL live in a shared package, uart_pkg.
REQ-029 The baud tick generator SHALL be a sub-module, uart_baud_gen (parameters CLK_HZ, BAUD; ports clk, reset, tick).

Verification
REQ-030 All scenarios use CLK_HZ = 1_600_000 and BAUD = 100_000, so DIV = 1 and one bit = 16 cycles.
REQ-031 Write TXD 0x000000A5 -> uart_tx carries 0,1,0,1,0,0,1,0,1,1 at 16-cycle spacing; CON reads 0x10 mid-frame and 0x08 after STOP.
REQ-032 Drive a 0x3C frame on uart_rx -> RXD reads 0x3C; CON reads 0x04, then 0x00 on the next read.
REQ-033 Drive a 0x55 frame on uart_rx with stop = 0 -> rx_done stays 0 and RXD keeps its previous value.
REQ-034 Write CON 0x3, then receive 0x81, with UART_IRQ_EN defined -> irq rises 1 cycle after rx_done; a CON read drops irq within 2 cycles; with the macro undefined, irq stays 0.
REQ-035 Write TXD 0x11, then write TXD 0x22 during DATA, then assert reset at bit 4 -> only 0x11 bits appear before reset; after reset uart_tx = 1 and CON = 0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, CON bit positions and FSM state encoding for the MMIO UART.
package uart_pkg;

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    localparam int CON_TX_IE   = 0;
    localparam int CON_RX_IE   = 1;
    localparam int CON_RX_DONE = 2;
    localparam int CON_TX_DONE = 3;
    localparam int CON_TX_BUSY = 4;

    // A bit spans 16 ticks; "tick 8" of a bit is sub-count 7, the last is 15.
    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Word-aligned match; the byte offset within the word is don't-care.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
        return (addr | 32'h3) == (reg_addr | 32'h3);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick generator: one-cycle tick every CLK_HZ/(BAUD*16) clocks.
module uart_baud_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON registers) with sticky done flags.
// Define UART_IRQ_EN to drive a registered level interrupt; otherwise irq is tied low.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    logic tick;

    uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    logic sel_txd, sel_rxd, sel_con, txd_wr, con_wr, con_rd;
    assign sel_txd = addr_hit(addr, ADDR_TXD);
    assign sel_rxd = addr_hit(addr, ADDR_RXD);
    assign sel_con = addr_hit(addr, ADDR_CON);
    assign txd_wr  = wr & sel_txd;
    assign con_wr  = wr & sel_con;
    assign con_rd  = rd & sel_con;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, wdata[31:8]};

    logic       tx_ie, rx_ie, tx_done, rx_done, tx_busy;
    logic [7:0] rx_byte;

    // ---------------- transmitter ----------------
    uart_state_t tx_state, tx_next;
    logic [3:0]  tx_sub;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_bit_end, tx_finish;

    assign tx_bit_end = tick && (tx_sub == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) tx_state <= ST_IDLE;
        else       tx_state <= tx_next;
    end

    // NOTE: default every always_comb output first so no path infers a latch.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:  if (tx_busy && tick)                  tx_next = ST_START;
            ST_START: if (tx_bit_end)                       tx_next = ST_DATA;
            ST_DATA:  if (tx_bit_end && (tx_bit == 3'd7))   tx_next = ST_STOP;
            ST_STOP:  if (tx_bit_end)                       tx_next = ST_IDLE;
            default:                                        tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_tx   = 1'b1;
        tx_finish = 1'b0;
        case (tx_state)
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = tx_shift[0];
            ST_STOP:  tx_finish = tx_bit_end;
            default:  uart_tx = 1'b1;
        endcase
    end

    // tx_busy gates the load, so a write during a frame cannot touch tx_shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_sub   <= '0;
            tx_bit   <= '0;
        end else begin
            if (txd_wr && !tx_busy) begin
                tx_busy  <= 1'b1;
                tx_shift <= wdata[7:0];
            end else if (tx_finish) begin
                tx_busy  <= 1'b0;
            end
            if (tx_state == ST_IDLE) begin
                tx_sub <= '0;
                tx_bit <= '0;
            end else if (tick) begin
                tx_sub <= tx_sub + 4'd1;
                if ((tx_state == ST_DATA) && (tx_sub == TICK_LAST)) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev, rx_fall, rx_mid, rx_end;

    // Synchronizer and edge history reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    uart_state_t rx_state, rx_next;
    logic [3:0]  rx_sub;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_sample, rx_good;

    assign rx_mid = tick && (rx_sub == TICK_MID);
    assign rx_end = tick && (rx_sub == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= ST_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:  if (rx_fall)                      rx_next = ST_START;
            ST_START: if (rx_mid && rx_s)               rx_next = ST_IDLE;
                      else if (rx_end)                  rx_next = ST_DATA;
            ST_DATA:  if (rx_end && (rx_bit == 3'd7))   rx_next = ST_STOP;
            ST_STOP:  if (rx_mid)                       rx_next = ST_IDLE;
            default:                                    rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_sample = (rx_state == ST_DATA) && rx_mid;
        rx_good   = (rx_state == ST_STOP) && rx_mid && rx_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == ST_IDLE) begin
            rx_sub <= '0;
            rx_bit <= '0;
        end else if (tick) begin
            rx_sub <= rx_sub + 4'd1;
            if (rx_sample)
                rx_shift <= {rx_s, rx_shift[7:1]};
            if ((rx_state == ST_DATA) && (rx_sub == TICK_LAST))
                rx_bit <= rx_bit + 3'd1;
        end
    end

    // ---------------- control/status ----------------
    // A set event outranks the read-to-clear of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ie   <= 1'b0;
            rx_ie   <= 1'b0;
            tx_done <= 1'b0;
            rx_done <= 1'b0;
            rx_byte <= '0;
        end else begin
            if (con_wr) begin
                tx_ie <= wdata[0];
                rx_ie <= wdata[1];
            end
            if (tx_finish)   tx_done <= 1'b1;
            else if (con_rd) tx_done <= 1'b0;
            if (rx_good) begin
                rx_done <= 1'b1;
                rx_byte <= rx_shift;
            end else if (con_rd) begin
                rx_done <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && sel_rxd) begin
            rdata[7:0] = rx_byte;
        end else if (rd && sel_con) begin
            rdata[CON_TX_IE]   = tx_ie;
            rdata[CON_RX_IE]   = rx_ie;
            rdata[CON_RX_DONE] = rx_done;
            rdata[CON_TX_DONE] = tx_done;
            rdata[CON_TX_BUSY] = tx_busy;
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= (tx_ie & tx_done) | (rx_ie & rx_done);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: bus reads and serial TX frames are checked by
// independent monitors against expectations pushed by the stimulus.
module tb_uart_mmio;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = 16;

    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        uart_rx, uart_tx, irq;

    uart_mmio #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    string       rd_name_q[$];
    logic [31:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    bit          tx_mon_off = 1'b1;

    // Behavioural model of the programmer-visible state.
    bit         m_tx_busy, m_tx_done, m_rx_done, m_tx_ie, m_rx_ie;
    logic [7:0] m_rx_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tx_busy = 0; m_tx_done = 0; m_rx_done = 0;
        m_tx_ie   = 0; m_rx_ie   = 0; m_rx_byte = 8'h00;
    endtask

    function automatic logic [31:0] con_model();
        return {27'b0, m_tx_busy, m_tx_done, m_rx_done, m_rx_ie, m_tx_ie};
    endfunction

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        rd_name_q.push_back(name);
        rd_exp_q.push_back(exp);
        @(posedge clk); #1;
        rd = 1'b1; addr = a;
        @(posedge clk); #1;
        rd = 1'b0; addr = '0;
    endtask

    task automatic read_con(input string name);
        bus_read(CON, con_model(), name);
        m_tx_done = 0;
        m_rx_done = 0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic tx_send(input logic [7:0] b);
        if (!m_tx_busy) begin
            tx_exp_q.push_back(b);
            m_tx_busy = 1;
        end
        bus_write(TXD, {24'hA5C3E1, b});
    endtask

    // A frame is 10 bits of 16 cycles plus the wait for the first tick.
    task automatic tx_finish_wait();
        repeat (175) @(posedge clk);
        #1;
        m_tx_busy = 0;
        m_tx_done = 1;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop, output int first_irq);
        int idx;
        first_irq = -1;
        for (int c = 0; c < 10 * BIT_CYC; c++) begin
            idx = c / BIT_CYC;
            @(posedge clk); #1;
            uart_rx = (idx == 0) ? 1'b0 : (idx == 9) ? stop : b[idx - 1];
            if (irq === 1'b1 && first_irq < 0) first_irq = c;
        end
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        if (stop) begin
            m_rx_byte = b;
            m_rx_done = 1;
        end
    endtask

    // Read monitor: every cycle with rd high consumes one expectation.
    string       mon_name;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (rd === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%08h, expected no read", rdata);
            end else begin
                mon_name = rd_name_q.pop_front();
                mon_exp  = rd_exp_q.pop_front();
                check(mon_name, rdata, mon_exp);
            end
        end
    end

    // TX monitor: decodes each frame mid-bit as {stop, data[7:0], start}.
    initial begin : tx_monitor
        logic [9:0] frame;
        logic [7:0] exp_b;
        forever begin
            @(negedge uart_tx);
            if (!tx_mon_off && reset === 1'b0) begin
                repeat (BIT_CYC / 2) @(posedge clk);
                #1;
                frame[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (BIT_CYC) @(posedge clk);
                    #1;
                    frame[i] = uart_tx;
                end
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_frame_unexpected: got frame 0x%03h, expected none", frame);
                end else begin
                    exp_b = tx_exp_q.pop_front();
                    check("tx_frame", {22'b0, frame}, {22'b0, 1'b1, exp_b, 1'b0});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "time limit reached");
    end

    initial begin : main
        int         first_irq;
        int         lows;
        logic [7:0] b, b2;
        bit         good;

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        tx_mon_off = 1'b0;

        addr = CON; #1;
        check("rdata_without_rd", rdata, 32'd0);
        addr = '0;
        read_con("reset_con");
        bus_read(RXD, 32'd0, "reset_rxd");
        bus_read(32'h4000_0024, 32'd0, "unmapped_read");

        // Transmit 0xA5; a second write mid-frame must be ignored.
        tx_send(8'hA5);
        repeat (40) @(posedge clk);
        read_con("con_tx_busy");
        tx_send(8'h77);
        repeat (140) @(posedge clk);
        #1;
        m_tx_busy = 0;
        m_tx_done = 1;
        read_con("con_tx_done");
        read_con("con_tx_done_cleared");

        // Good receive, then a framing error that must not disturb rx_byte.
        send_rx(8'h3C, 1'b1, first_irq);
        bus_read(RXD, {24'b0, m_rx_byte}, "rxd_3c");
        read_con("con_rx_done");
        read_con("con_rx_done_cleared");
        send_rx(8'h55, 1'b0, first_irq);
        read_con("con_framing_error");
        bus_read(RXD | 32'h3, {24'b0, m_rx_byte}, "rxd_after_framing_error");

        // Random concurrent TX and RX frames.
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom);
            b2   = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            fork
                begin
                    tx_send(b);
                    tx_finish_wait();
                end
                begin
                    int fi;
                    send_rx(b2, good, fi);
                end
            join
            bus_read(RXD, {24'b0, m_rx_byte}, "rxd_random");
            read_con("con_random");
        end

        // Interrupt enables; status bits in the write data must not stick.
        bus_write(CON, 32'h0000_001F);
        m_tx_ie = 1;
        m_rx_ie = 1;
        check("irq_idle_enabled", {31'b0, irq}, 32'd0);
        send_rx(8'h81, 1'b1, first_irq);
`ifdef UART_IRQ_EN
        check("irq_rises_in_stop_bit", {31'b0, (first_irq >= 144 && first_irq < 160)}, 32'd1);
        check("irq_high_after_rx", {31'b0, irq}, 32'd1);
`else
        check("irq_tied_low_during_rx", first_irq, -1);
        check("irq_tied_low_after_rx", {31'b0, irq}, 32'd0);
`endif
        read_con("con_irq_pending");
        @(posedge clk); #1;
        check("irq_cleared_after_con_read", {31'b0, irq}, 32'd0);
        bus_read(RXD, {24'b0, m_rx_byte}, "rxd_81");
        bus_write(CON, 32'h0);
        m_tx_ie = 0;
        m_rx_ie = 0;

        // Reset in the middle of a frame; 0x22 written during DATA must not appear.
        tx_mon_off = 1'b1;
        b = 8'h11;
        bus_write(TXD, {24'b0, b});
        repeat (24) @(posedge clk);
        #1;
        check("abort_bit0", {31'b0, uart_tx}, {31'b0, b[0]});
        bus_write(TXD, 32'h0000_0022);
        repeat (15) @(posedge clk);
        #1;
        check("abort_bit1", {31'b0, uart_tx}, {31'b0, b[1]});
        for (int k = 2; k < 5; k++) begin
            repeat (BIT_CYC) @(posedge clk);
            #1;
            check($sformatf("abort_bit%0d", k), {31'b0, uart_tx}, {31'b0, b[k]});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("uart_tx_in_reset", {31'b0, uart_tx}, 32'd1);
        check("irq_in_reset", {31'b0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        read_con("con_after_reset");
        bus_read(RXD, 32'd0, "rxd_after_reset");
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_frame_after_reset", lows, 0);
        tx_mon_off = 1'b0;

        tx_send(8'($urandom));
        tx_finish_wait();
        read_con("con_tx_after_reset");
        repeat (4) @(posedge clk);

        check("read_queue_drained", rd_exp_q.size(), 0);
        check("tx_queue_drained", tx_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
